// File: rtl/rk_pingpong_vec_mem.sv
// Two-bank wide-vector residual store: current/prev banks swap roles on an index flip,
// one lane-masked write port on current, registered read ports on both, and a clear sequencer.
module rk_pingpong_vec_mem #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int depth         = 1024,
    parameter int address_width = 10
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   wr_en,
    input  logic [address_width-1:0]               wr_addr,
    input  logic [element_width*no_of_units-1:0]   wr_data,
    input  logic [no_of_units-1:0]                 wr_lane_mask,
    input  logic                                   rd_en_cur,
    input  logic [address_width-1:0]               rd_addr_cur,
    output logic [element_width*no_of_units-1:0]   rd_data_cur,
    output logic                                   rd_valid_cur,
    input  logic                                   rd_en_prev,
    input  logic [address_width-1:0]               rd_addr_prev,
    output logic [element_width*no_of_units-1:0]   rd_data_prev,
    output logic                                   rd_valid_prev,
    input  logic                                   swap,
    input  logic                                   clear_start,
    output logic                                   clear_busy,
    output logic                                   active_bank,
    output logic                                   err
);
    localparam int W  = element_width * no_of_units;
    localparam int IW = (depth > 1) ? $clog2(depth) : 1;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic            clr_we;
    logic            active_q;
    logic [W-1:0]    rd_cur_q, rd_prev_q;
    logic            vld_cur_q, vld_prev_q, err_q;
    logic [W-1:0]    mem [2][depth];

    function automatic logic in_range(input logic [address_width-1:0] a);
        return 32'(a) < 32'(depth);
    endfunction

    logic          wr_ok, byp, cur_ok, prev_ok, err_d;
    logic [IW-1:0] wr_idx, rc_idx, rp_idx;
    logic [W-1:0]  cur_raw, cur_word, prev_word;

    assign wr_idx  = wr_addr[IW-1:0];
    assign rc_idx  = rd_addr_cur[IW-1:0];
    assign rp_idx  = rd_addr_prev[IW-1:0];
    assign cur_ok  = in_range(rd_addr_cur);
    assign prev_ok = in_range(rd_addr_prev);
    assign wr_ok   = wr_en && in_range(wr_addr) && !clear_busy;
    assign byp     = wr_ok && (wr_addr == rd_addr_cur);
    assign cur_raw   = mem[active_q][rc_idx];
    assign prev_word = mem[~active_q][rp_idx];

    // Write-first bypass: lanes being written this cycle come straight from wr_data.
    for (genvar i = 0; i < no_of_units; i++) begin : g_lane
        localparam int LO = i * element_width;
        assign cur_word[LO +: element_width] = (byp && wr_lane_mask[i]) ?
            wr_data[LO +: element_width] : cur_raw[LO +: element_width];
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[active_q][cnt_q] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < no_of_units; i++) begin
                if (wr_lane_mask[i])
                    mem[active_q][wr_idx][i*element_width +: element_width] <=
                        wr_data[i*element_width +: element_width];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (clear_start) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
            CLEAR: begin
                cnt_d = cnt_q + IW'(1);
                if (32'(cnt_q) == 32'(depth - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clear_busy = (state_q == CLEAR);
        clr_we     = (state_q == CLEAR);
    end

    assign err_d = (wr_en && (!in_range(wr_addr) || clear_busy))
                 | (swap && clear_busy)
                 | (clear_start && clear_busy)
                 | (rd_en_cur && !cur_ok)
                 | (rd_en_prev && !prev_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            rd_cur_q   <= '0;
            rd_prev_q  <= '0;
            vld_cur_q  <= 1'b0;
            vld_prev_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (swap && !clear_busy) active_q <= ~active_q;
            vld_cur_q  <= rd_en_cur;
            vld_prev_q <= rd_en_prev;
            if (rd_en_cur)  rd_cur_q  <= cur_ok  ? cur_word  : '0;
            if (rd_en_prev) rd_prev_q <= prev_ok ? prev_word : '0;
            err_q <= err_d;
        end
    end

    assign active_bank   = active_q;
    assign rd_data_cur   = rd_cur_q;
    assign rd_valid_cur  = vld_cur_q;
    assign rd_data_prev  = rd_prev_q;
    assign rd_valid_prev = vld_prev_q;
    assign err           = err_q;
endmodule

// File: tb/tb_rk_pingpong_vec_mem.sv
// Bench for rk_pingpong_vec_mem: array-based reference model checked every cycle,
// plus literal expectations on the directed sequence.
module tb_rk_pingpong_vec_mem;
    localparam int EW = 32, N = 4, D = 16, AW = 10, W = EW * N;

    logic          clk, rst_n;
    logic          wr_en, rd_en_cur, rd_en_prev, swap, clear_start;
    logic [AW-1:0] wr_addr, rd_addr_cur, rd_addr_prev;
    logic [W-1:0]  wr_data, rd_data_cur, rd_data_prev;
    logic [N-1:0]  wr_lane_mask;
    logic          rd_valid_cur, rd_valid_prev, clear_busy, active_bank, err;

    rk_pingpong_vec_mem #(.element_width(EW), .no_of_units(N), .depth(D), .address_width(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lane_mask(wr_lane_mask),
        .rd_en_cur(rd_en_cur), .rd_addr_cur(rd_addr_cur), .rd_data_cur(rd_data_cur),
        .rd_valid_cur(rd_valid_cur),
        .rd_en_prev(rd_en_prev), .rd_addr_prev(rd_addr_prev), .rd_data_prev(rd_data_prev),
        .rd_valid_prev(rd_valid_prev),
        .swap(swap), .clear_start(clear_start), .clear_busy(clear_busy),
        .active_bank(active_bank), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] v4(input int a3, input int a2, input int a1, input int a0);
        return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    endfunction

    // Reference model: two plain arrays, a bank index, and a remaining-cycles clear count.
    logic [W-1:0] m [2][D];
    bit           kn [2][D];
    bit           m_act = 0, m_busy = 0, m_e = 0, m_cur = 0;
    int           busy_left = 0, clr_idx = 0, a_i = 0;
    logic [W-1:0] e_dc = '0, e_dp = '0;
    bit           e_vc = 0, e_vp = 0, e_kc = 1, e_kp = 1, e_err = 0, e_busy = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; busy_left = 0; clr_idx = 0;
            e_dc = '0; e_dp = '0; e_vc = 0; e_vp = 0; e_kc = 1; e_kp = 1; e_err = 0;
        end else begin
            m_busy = busy_left > 0;
            m_e    = 0;
            m_cur  = m_act;
            if (wr_en) begin
                a_i = int'(wr_addr);
                if (a_i >= D || m_busy) m_e = 1;
                else begin
                    for (int i = 0; i < N; i++)
                        if (wr_lane_mask[i]) m[m_cur][a_i][i*EW +: EW] = wr_data[i*EW +: EW];
                    if (wr_lane_mask == '1) kn[m_cur][a_i] = 1;
                end
            end
            e_vc = rd_en_cur;
            if (rd_en_cur) begin
                a_i = int'(rd_addr_cur);
                if (a_i >= D) begin e_dc = '0; e_kc = 1; m_e = 1; end
                else begin e_dc = m[m_cur][a_i]; e_kc = kn[m_cur][a_i]; end
            end
            e_vp = rd_en_prev;
            if (rd_en_prev) begin
                a_i = int'(rd_addr_prev);
                if (a_i >= D) begin e_dp = '0; e_kp = 1; m_e = 1; end
                else begin e_dp = m[!m_cur][a_i]; e_kp = kn[!m_cur][a_i]; end
            end
            if (swap) begin
                if (m_busy) m_e = 1;
                else m_act = !m_act;
            end
            if (clear_start && m_busy) m_e = 1;
            if (m_busy) begin
                m[m_cur][clr_idx] = '0;
                kn[m_cur][clr_idx] = 1;
                clr_idx++;
                busy_left--;
            end else if (clear_start) begin
                busy_left = D;
                clr_idx   = 0;
            end
            e_err = m_e;
        end
        e_busy = busy_left > 0;
    end

    always @(negedge clk) begin
        chk("active_bank", W'(active_bank), W'(m_act));
        chk("clear_busy", W'(clear_busy), W'(e_busy));
        chk("err", W'(err), W'(e_err));
        chk("rd_valid_cur", W'(rd_valid_cur), W'(e_vc));
        chk("rd_valid_prev", W'(rd_valid_prev), W'(e_vp));
        if (e_kc) chk("rd_data_cur", rd_data_cur, e_dc);
        if (e_kp) chk("rd_data_prev", rd_data_prev, e_dp);
    end

    task automatic cyc();
        @(posedge clk); #2;
        wr_en = 0; rd_en_cur = 0; rd_en_prev = 0; swap = 0; clear_start = 0;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d, input logic [N-1:0] mk);
        wr_en = 1; wr_addr = AW'(a); wr_data = d; wr_lane_mask = mk;
    endtask

    task automatic rdc(input int a); rd_en_cur = 1; rd_addr_cur = AW'(a); endtask
    task automatic rdp(input int a); rd_en_prev = 1; rd_addr_prev = AW'(a); endtask

    int n;

    initial begin
        rst_n = 0; wr_en = 0; rd_en_cur = 0; rd_en_prev = 0; swap = 0; clear_start = 0;
        wr_addr = '0; rd_addr_cur = '0; rd_addr_prev = '0; wr_data = '0; wr_lane_mask = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset active_bank", W'(active_bank), '0);
        chk("reset rd_data_cur", rd_data_cur, '0);
        chk("reset err", W'(err), '0);
        chk("reset clear_busy", W'(clear_busy), '0);
        rst_n = 1;
        cyc();

        wr(3, v4(4, 3, 2, 1), 4'hF); cyc();
        rdc(3); cyc();
        chk("first read valid", W'(rd_valid_cur), W'(1));
        chk("first read data", rd_data_cur, v4(4, 3, 2, 1));
        cyc();
        chk("valid drops", W'(rd_valid_cur), '0);
        chk("data holds", rd_data_cur, v4(4, 3, 2, 1));

        wr(3, v4(8, 7, 6, 5), 4'b0101); cyc();
        rdc(3); cyc();
        chk("masked merge", rd_data_cur, v4(4, 7, 2, 5));
        wr(5, v4(1, 2, 3, 4), 4'hF); cyc();
        wr(5, v4(9, 9, 9, 9), 4'b0010); rdc(5); cyc();
        chk("write-first bypass", rd_data_cur, v4(1, 2, 9, 4));

        swap = 1; cyc();
        chk("swap bank", W'(active_bank), W'(1));
        rdp(3); cyc();
        chk("prev after swap", rd_data_prev, v4(4, 7, 2, 5));
        wr(3, v4(9, 9, 9, 9), 4'hF); rdp(3); cyc();
        chk("prev ignores write", rd_data_prev, v4(4, 7, 2, 5));
        rdc(3); cyc();
        chk("new cur word", rd_data_cur, v4(9, 9, 9, 9));

        for (int a = 0; a < D; a++) begin wr(a, v4(a+1, a+2, a+3, a+4), 4'hF); cyc(); end
        clear_start = 1; cyc();
        n = 0;
        while (clear_busy === 1'b1 && n < 100) begin n++; cyc(); end
        chk("clear busy cycles", W'(n), W'(D));
        for (int a = 0; a < D; a++) begin rdc(a); cyc(); chk("cleared word", rd_data_cur, '0); end
        rdp(3); cyc();
        chk("prev intact 3", rd_data_prev, v4(4, 7, 2, 5));
        rdp(5); cyc();
        chk("prev intact 5", rd_data_prev, v4(1, 2, 9, 4));

        clear_start = 1; cyc();
        swap = 1; cyc();
        chk("swap in clear err", W'(err), W'(1));
        chk("swap in clear ignored", W'(active_bank), W'(1));
        wr(2, v4(5, 5, 5, 5), 4'hF); cyc();
        chk("write in clear err", W'(err), W'(1));
        clear_start = 1; cyc();
        chk("restart in clear err", W'(err), W'(1));
        cyc();
        chk("err single pulse", W'(err), '0);
        n = 0;
        while (clear_busy === 1'b1 && n < 100) begin n++; cyc(); end
        chk("clear finished", W'(clear_busy), '0);
        rdc(20); cyc();
        chk("oor read valid", W'(rd_valid_cur), W'(1));
        chk("oor read data", rd_data_cur, '0);
        chk("oor read err", W'(err), W'(1));
        wr(20, v4(1, 1, 1, 1), 4'hF); cyc();
        chk("oor write err", W'(err), W'(1));

        swap = 1; cyc();
        chk("swap back", W'(active_bank), '0);
        for (int a = 0; a < D; a++) begin wr(a, v4(a+50, a+60, a+70, a+80), 4'hF); cyc(); end
        clear_start = 1; cyc();
        repeat (7) cyc();
        rst_n = 0;
        #1;
        chk("reset aborts clear", W'(clear_busy), '0);
        cyc(); cyc();
        rst_n = 1;
        chk("bank after reset", W'(active_bank), '0);
        for (int a = 0; a < D; a++) begin
            rdc(a); cyc();
            chk("partial clear", rd_data_cur, (a < 7) ? '0 : v4(a+50, a+60, a+70, a+80));
        end
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
